i2c_slave_target_fsm: RTL

//  Pin-level I2C target: consumes the SCL/SDA bus the master BFM drives, decodes

---
 rtl/i2c_slave_target_fsm_if.sv | 53 +++++
 rtl/i2c_slave_target_fsm.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_target_fsm_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_target_fsm_if
// Bundles the I2C pin-level lines and the register-bank strobe port of one
// i2c_slave_target_fsm instance.
//   scl_i, sda_i    : bus levels seen by the target (SDA already wired-AND)
//   sda_oe          : 1 = target pulls SDA low, 0 = released
//   reg_wr_valid    : one-clock write strobe to the register bank
//   reg_addr        : current register pointer
//   reg_wr_data     : write data, valid with reg_wr_valid
//   reg_rd_data     : read data for reg_addr, supplied by the register bank
//   busy            : START seen and no STOP yet
//   stop_det        : one-clock pulse on STOP
// Modports: slave = the target FSM, master = bus/register-bank side.
// ----------------------------------------------------------------------------
interface i2c_slave_target_fsm_if #(
    parameter int REG_DEPTH = 4
);
    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          reg_wr_valid;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wr_data;
    logic [7:0]    reg_rd_data;
    logic          busy;
    logic          stop_det;

    modport slave (
        input  scl_i,
        input  sda_i,
        input  reg_rd_data,
        output sda_oe,
        output reg_wr_valid,
        output reg_addr,
        output reg_wr_data,
        output busy,
        output stop_det
    );

    modport master (
        output scl_i,
        output sda_i,
        output reg_rd_data,
        input  sda_oe,
        input  reg_wr_valid,
        input  reg_addr,
        input  reg_wr_data,
        input  busy,
        input  stop_det
    );
endinterface

// File: rtl/i2c_slave_target_fsm.sv
// ----------------------------------------------------------------------------
// i2c_slave_target_fsm
// Pin-level I2C target with 7-bit addressing and a single register-address
// byte. Decodes START / address / R-W / register address / data from the
// SCL/SDA levels, drives ACK and read data open-drain on SDA, and feeds a
// user register bank through a write strobe plus a register pointer.
//
// Ports:
//   pclk    : system clock, at least 8x the SCL rate
//   areset  : asynchronous active-low reset
//   bus     : i2c_slave_target_fsm_if.slave (SCL/SDA, sda_oe, register port,
//             busy, stop_det)
//
// Optional build macro:
//   I2C_GLITCH_FILTER_EN : when defined, each synchronized line only changes
//   after FILTER_LEN consecutive identical samples, so shorter pulses are
//   rejected (adds FILTER_LEN clocks of latency). When undefined the
//   synchronized levels are used directly and FILTER_LEN has no effect.
// ----------------------------------------------------------------------------
module i2c_slave_target_fsm #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
    parameter int         REG_DEPTH     = 4,
    parameter int         DATA_WIDTH    = 8,
    parameter int         FILTER_LEN    = 3
) (
    input  logic                   pclk,
    input  logic                   areset,
    i2c_slave_target_fsm_if.slave  bus
);

    localparam int         AW        = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
    localparam logic [3:0] BYTE_BITS = 4'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        REG       = 4'd3,
        REG_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RACK      = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    // Register pointer increment with wrap at the last implemented register.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        logic [AW-1:0] n;
        if (a == AW'(REG_DEPTH - 1)) begin
            n = '0;
        end else begin
            n = a + AW'(1);
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Input path: 2-flop synchronizers, optional filter, history flops
    // ------------------------------------------------------------------
    logic scl_s1_r, scl_s2_r, sda_s1_r, sda_s2_r;
    logic scl_f_s, sda_f_s;
    logic scl_h_r, sda_h_r;

    // Synchronize the asynchronous bus levels and keep one sample of history.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
            scl_h_r  <= 1'b1;
            sda_h_r  <= 1'b1;
        end else begin
            scl_s1_r <= bus.scl_i;
            scl_s2_r <= scl_s1_r;
            sda_s1_r <= bus.sda_i;
            sda_s2_r <= sda_s1_r;
            scl_h_r  <= scl_f_s;
            sda_h_r  <= sda_f_s;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic           scl_flt_r, sda_flt_r;
    logic [FCW-1:0] scl_cnt_r, sda_cnt_r;

    // A line follows the synchronized level only after FILTER_LEN equal samples.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            scl_flt_r <= 1'b1;
            sda_flt_r <= 1'b1;
            scl_cnt_r <= '0;
            sda_cnt_r <= '0;
        end else begin
            if (scl_s2_r == scl_flt_r) begin
                scl_cnt_r <= '0;
            end else if (scl_cnt_r == FCW'(FILTER_LEN - 1)) begin
                scl_flt_r <= scl_s2_r;
                scl_cnt_r <= '0;
            end else begin
                scl_cnt_r <= scl_cnt_r + FCW'(1);
            end

            if (sda_s2_r == sda_flt_r) begin
                sda_cnt_r <= '0;
            end else if (sda_cnt_r == FCW'(FILTER_LEN - 1)) begin
                sda_flt_r <= sda_s2_r;
                sda_cnt_r <= '0;
            end else begin
                sda_cnt_r <= sda_cnt_r + FCW'(1);
            end
        end
    end

    assign scl_f_s = scl_flt_r;
    assign sda_f_s = sda_flt_r;
`else
    logic unused_filter_cfg_s;

    assign scl_f_s             = scl_s2_r;
    assign sda_f_s             = sda_s2_r;
    assign unused_filter_cfg_s = (FILTER_LEN > 0);
`endif

    // ------------------------------------------------------------------
    // Bus event decode
    // ------------------------------------------------------------------
    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    assign scl_rise_s = scl_f_s & ~scl_h_r;
    assign scl_fall_s = ~scl_f_s & scl_h_r;
    // SDA edges count only with SCL stable high on both samples, so an SDA
    // edge coinciding with an SCL edge is never taken as START/STOP.
    assign start_s    = scl_f_s & scl_h_r & sda_h_r & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_h_r & ~sda_h_r & sda_f_s;

    // ------------------------------------------------------------------
    // Protocol FSM with registered outputs
    // ------------------------------------------------------------------
    state_t        state_r;
    logic [3:0]    bit_cnt_r;
    logic [7:0]    rx_r;
    logic [7:0]    tx_r;
    logic          rw_r;
    logic          sda_oe_r;
    logic          wr_valid_r;
    logic [AW-1:0] reg_addr_r;
    logic [7:0]    wr_data_r;
    logic          busy_r;
    logic          stop_det_r;
    logic          rx_phase_s;

    assign rx_phase_s = (state_r == ADDR) || (state_r == REG) || (state_r == WDATA);

    // Protocol sequencing, SDA drive and register-port strobes.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            rx_r       <= 8'h00;
            tx_r       <= 8'h00;
            rw_r       <= 1'b0;
            sda_oe_r   <= 1'b0;
            wr_valid_r <= 1'b0;
            reg_addr_r <= '0;
            wr_data_r  <= 8'h00;
            busy_r     <= 1'b0;
            stop_det_r <= 1'b0;
        end else begin
            wr_valid_r <= 1'b0;
            stop_det_r <= 1'b0;

            if (stop_s) begin
                state_r    <= IDLE;
                sda_oe_r   <= 1'b0;
                stop_det_r <= 1'b1;
                busy_r     <= 1'b0;
                bit_cnt_r  <= 4'd0;
            end else if (start_s) begin
                state_r   <= ADDR;
                bit_cnt_r <= 4'd0;
                sda_oe_r  <= 1'b0;
                busy_r    <= 1'b1;
            end else begin
                // Receive shift is shared by all master-to-target byte phases.
                if (rx_phase_s && scl_rise_s && (bit_cnt_r < BYTE_BITS)) begin
                    rx_r      <= {rx_r[6:0], sda_f_s};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                end

                case (state_r)
                    IDLE: begin
                        sda_oe_r <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            if (rx_r[7:1] == SLAVE_ADDRESS) begin
                                state_r  <= ADDR_ACK;
                                sda_oe_r <= 1'b1;
                                rw_r     <= rx_r[0];
                            end else begin
                                state_r  <= WAIT_STOP;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (rw_r) begin
                                // The fall ending the ACK also launches the first read bit.
                                state_r   <= RDATA;
                                sda_oe_r  <= ~bus.reg_rd_data[7];
                                tx_r      <= {bus.reg_rd_data[6:0], 1'b0};
                                bit_cnt_r <= 4'd1;
                            end else begin
                                state_r   <= REG;
                                sda_oe_r  <= 1'b0;
                                bit_cnt_r <= 4'd0;
                            end
                        end
                    end

                    REG: begin
                        if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            if ({24'd0, rx_r} < 32'(REG_DEPTH)) begin
                                reg_addr_r <= rx_r[AW-1:0];
                                sda_oe_r   <= 1'b1;
                                state_r    <= REG_ACK;
                            end else begin
                                state_r    <= WAIT_STOP;
                            end
                        end
                    end

                    REG_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe_r  <= 1'b0;
                            state_r   <= WDATA;
                            bit_cnt_r <= 4'd0;
                        end
                    end

                    WDATA: begin
                        if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            wr_data_r  <= rx_r;
                            wr_valid_r <= 1'b1;
                            sda_oe_r   <= 1'b1;
                            state_r    <= WDATA_ACK;
                        end
                    end

                    WDATA_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe_r   <= 1'b0;
                            reg_addr_r <= next_addr(reg_addr_r);
                            state_r    <= WDATA;
                            bit_cnt_r  <= 4'd0;
                        end
                    end

                    RDATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd0) begin
                                // First bit of a follow-on byte after a master ACK.
                                sda_oe_r  <= ~bus.reg_rd_data[7];
                                tx_r      <= {bus.reg_rd_data[6:0], 1'b0};
                                bit_cnt_r <= 4'd1;
                            end else if (bit_cnt_r < BYTE_BITS) begin
                                sda_oe_r  <= ~tx_r[7];
                                tx_r      <= {tx_r[6:0], 1'b0};
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end else begin
                                sda_oe_r  <= 1'b0;
                                state_r   <= RACK;
                                bit_cnt_r <= 4'd0;
                            end
                        end
                    end

                    RACK: begin
                        if (scl_rise_s) begin
                            if (!sda_f_s) begin
                                reg_addr_r <= next_addr(reg_addr_r);
                                state_r    <= RDATA;
                                bit_cnt_r  <= 4'd0;
                            end else begin
                                state_r    <= WAIT_STOP;
                            end
                        end
                    end

                    WAIT_STOP: begin
                        sda_oe_r <= 1'b0;
                    end

                    default: begin
                        state_r  <= IDLE;
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe       = sda_oe_r;
    assign bus.reg_wr_valid = wr_valid_r;
    assign bus.reg_addr     = reg_addr_r;
    assign bus.reg_wr_data  = wr_data_r;
    assign bus.busy         = busy_r;
    assign bus.stop_det     = stop_det_r;

endmodule
